// File: rtl/mem_responder_pkg.sv
// Shared constants for the CPU word-memory responder: FSM encodings and default latency.
package mem_responder_pkg;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'b00,
    MEM_WAIT = 2'b01,
    MEM_RESP = 2'b10
  } mem_state_t;

  localparam int MEM_DATA_W              = 16;
  localparam int MEM_WAIT_CYCLES_DEFAULT = 1;

endpackage

// File: rtl/mem_word_array.sv
// DEPTH x 16 word array: synchronous write, combinational read, write port shared
// between the preload path and the transaction path.
module mem_word_array
  import mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 256
) (
  input  logic                  clock,
  input  logic                  sel_txn,
  input  logic                  init_we,
  input  logic [ADDR_WIDTH-1:0] init_addr,
  input  logic [MEM_DATA_W-1:0] init_data,
  input  logic                  txn_we,
  input  logic [ADDR_WIDTH-1:0] txn_addr,
  input  logic [MEM_DATA_W-1:0] txn_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [MEM_DATA_W-1:0] rd_data
);

  logic [MEM_DATA_W-1:0] mem [DEPTH];
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [MEM_DATA_W-1:0] wr_data;

  assign wr_en   = sel_txn ? txn_we   : init_we;
  assign wr_addr = sel_txn ? txn_addr : init_addr;
  assign wr_data = sel_txn ? txn_data : init_data;

  // Addresses beyond DEPTH are silently dropped on both ports.
  always_ff @(posedge clock) begin
    if (wr_en && (32'(wr_addr) < DEPTH))
      mem[wr_addr] <= wr_data;
  end

  assign rd_data = (32'(rd_addr) < DEPTH) ? mem[rd_addr] : '0;

endmodule

// File: rtl/mem_responder.sv
// Word-memory responder: valid/ready request-response with programmable wait states
// and a side-band preload port.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = MEM_WAIT_CYCLES_DEFAULT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [MEM_DATA_W-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [MEM_DATA_W-1:0] rsp_rdata,
  output logic                  rsp_error,
  input  logic                  init_we,
  input  logic [ADDR_WIDTH-1:0] init_addr,
  input  logic [MEM_DATA_W-1:0] init_data
);

  localparam int CNT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);

  mem_state_t            state;
  logic [CNT_W-1:0]      cnt;
  logic                  lat_write;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [MEM_DATA_W-1:0] lat_wdata;
  logic [MEM_DATA_W-1:0] rd_data;
  logic                  entry;
  logic                  addr_ok;

  assign req_ready = reset && (state == MEM_IDLE) && !init_we;

  // RESP is entered with rsp_valid low; the first RESP cycle performs the access.
  assign entry   = (state == MEM_RESP) && !rsp_valid;
  assign addr_ok = 32'(lat_addr) < DEPTH;

  mem_word_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_array (
    .clock     (clock),
    .sel_txn   (state == MEM_RESP),
    .init_we   (reset && (state == MEM_IDLE) && init_we),
    .init_addr (init_addr),
    .init_data (init_data),
    .txn_we    (reset && entry && lat_write),
    .txn_addr  (lat_addr),
    .txn_data  (lat_wdata),
    .rd_addr   (lat_addr),
    .rd_data   (rd_data)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= MEM_IDLE;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
    end else begin
      case (state)
        MEM_IDLE: begin
          if (req_valid && req_ready) begin
            lat_write <= req_write;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            cnt       <= CNT_W'(WAIT_CYCLES);
            state     <= (WAIT_CYCLES > 0) ? MEM_WAIT : MEM_RESP;
          end
        end
        MEM_WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt <= CNT_W'(1))
            state <= MEM_RESP;
        end
        MEM_RESP: begin
          if (!rsp_valid) begin
            rsp_valid <= 1'b1;
            rsp_error <= !addr_ok;
            rsp_rdata <= (!addr_ok || lat_write) ? '0 : rd_data;
          end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= MEM_IDLE;
          end
        end
        default: state <= MEM_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (DEPTH=200/W=1, W=3, W=0) checked against a
// word-array model with latency computed from WAIT_CYCLES.
module tb_mem_responder;

  localparam int N = 3;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid [N];
  logic        req_ready [N];
  logic        req_write [N];
  logic [7:0]  req_addr  [N];
  logic [15:0] req_wdata [N];
  logic        rsp_valid [N];
  logic        rsp_ready [N];
  logic [15:0] rsp_rdata [N];
  logic        rsp_error [N];
  logic        init_we   [N];
  logic [7:0]  init_addr [N];
  logic [15:0] init_data [N];

  logic [15:0] mdl [N][256];
  int n_assert = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  for (genvar g = 0; g < N; g++) begin : g_dut
    mem_responder #(
      .ADDR_WIDTH  (8),
      .DEPTH       (g == 0 ? 200 : 256),
      .WAIT_CYCLES (g == 0 ? 1 : (g == 1 ? 3 : 0))
    ) dut (
      .clock     (clock),
      .reset     (reset),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_write (req_write[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_ready (rsp_ready[g]),
      .rsp_rdata (rsp_rdata[g]),
      .rsp_error (rsp_error[g]),
      .init_we   (init_we[g]),
      .init_addr (init_addr[g]),
      .init_data (init_data[g])
    );
  end

  function automatic int depth_of(input int d);
    return (d == 0) ? 200 : 256;
  endfunction

  function automatic int wait_of(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 3 : 0);
  endfunction

  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, obs, exp);
    end
  endtask

  // One full transaction; called just after a negedge, returns just after a negedge.
  task automatic txn(input int d, input bit wr, input logic [7:0] a, input logic [15:0] wd,
                     input int hold);
    int k;
    logic        ee;
    logic [15:0] er;
    ee = (int'(a) >= depth_of(d));
    er = (ee || wr) ? 16'h0 : mdl[d][a];
    req_valid[d] = 1'b1;
    req_write[d] = wr;
    req_addr[d]  = a;
    req_wdata[d] = wd;
    #1 chk("req_ready_idle", d, 32'(req_ready[d]), 32'd1);
    @(posedge clock);
    @(negedge clock);
    req_valid[d] = 1'b0;
    req_write[d] = 1'($urandom);
    req_addr[d]  = 8'($urandom);
    req_wdata[d] = 16'($urandom);
    #1 chk("req_ready_busy", d, 32'(req_ready[d]), 32'd0);
    k = 0;
    while (!rsp_valid[d] && k < 20) begin
      @(negedge clock);
      #1 k++;
    end
    chk("latency", d, 32'(k), 32'(1 + wait_of(d)));
    chk("rdata", d, 32'(rsp_rdata[d]), 32'(er));
    chk("error", d, 32'(rsp_error[d]), 32'(ee));
    for (int h = 0; h < hold; h++) begin
      @(negedge clock);
      #1 chk("hold_valid", d, 32'(rsp_valid[d]), 32'd1);
      chk("hold_rdata", d, 32'(rsp_rdata[d]), 32'(er));
      chk("hold_error", d, 32'(rsp_error[d]), 32'(ee));
      chk("hold_req_ready", d, 32'(req_ready[d]), 32'd0);
    end
    rsp_ready[d] = 1'b1;
    @(posedge clock);
    @(negedge clock);
    rsp_ready[d] = 1'b0;
    #1 chk("valid_drop", d, 32'(rsp_valid[d]), 32'd0);
    chk("req_ready_back", d, 32'(req_ready[d]), 32'd1);
    chk("rdata_retained", d, 32'(rsp_rdata[d]), 32'(er));
    if (wr && !ee) mdl[d][a] = wd;
  endtask

  initial begin
    logic [15:0] v;
    reset = 1'b0;
    for (int d = 0; d < N; d++) begin
      req_valid[d] = 1'b0; req_write[d] = 1'b0; req_addr[d] = '0; req_wdata[d] = '0;
      rsp_ready[d] = 1'b0; init_we[d] = 1'b0; init_addr[d] = '0; init_data[d] = '0;
    end

    // Reset held for three cycles.
    repeat (3) begin
      @(negedge clock);
      #1 for (int d = 0; d < N; d++) begin
        chk("rst_req_ready", d, 32'(req_ready[d]), 32'd0);
        chk("rst_rsp_valid", d, 32'(rsp_valid[d]), 32'd0);
      end
    end
    reset = 1'b1;
    #1 for (int d = 0; d < N; d++) chk("post_rst_ready", d, 32'(req_ready[d]), 32'd1);

    // Preload every word with random data, then mem[0x05]=0xBEEF.
    for (int a = 0; a < 256; a++) begin
      for (int d = 0; d < N; d++) begin
        v = 16'($urandom);
        init_we[d] = 1'b1; init_addr[d] = 8'(a); init_data[d] = v;
        if (a < depth_of(d)) mdl[d][a] = v;
      end
      @(posedge clock);
      @(negedge clock);
    end
    for (int d = 0; d < N; d++) begin
      init_addr[d] = 8'h05; init_data[d] = 16'hBEEF; mdl[d][5] = 16'hBEEF;
    end
    #1 for (int d = 0; d < N; d++) chk("init_req_ready", d, 32'(req_ready[d]), 32'd0);
    @(posedge clock);
    @(negedge clock);
    for (int d = 0; d < N; d++) init_we[d] = 1'b0;
    #1 for (int d = 0; d < N; d++) chk("after_init_ready", d, 32'(req_ready[d]), 32'd1);

    // Directed reads/writes on the W=1, DEPTH=200 instance.
    txn(0, 1'b0, 8'h05, 16'h0, 0);
    txn(0, 1'b1, 8'h10, 16'h1234, 4);
    txn(0, 1'b0, 8'h10, 16'h0, 1);
    txn(0, 1'b1, 8'hC8, 16'hFFFF, 1);
    txn(0, 1'b0, 8'hC8, 16'h0, 0);
    txn(0, 1'b0, 8'h48, 16'h0, 0);

    // Reset during the second WAIT cycle of a W=3 write: no response, no write.
    req_valid[1] = 1'b1; req_write[1] = 1'b1; req_addr[1] = 8'h20; req_wdata[1] = 16'hAAAA;
    @(posedge clock);
    @(negedge clock);
    req_valid[1] = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    repeat (5) begin
      @(negedge clock);
      #1 chk("abort_rsp_valid", 1, 32'(rsp_valid[1]), 32'd0);
      chk("abort_req_ready", 1, 32'(req_ready[1]), 32'd0);
    end
    reset = 1'b1;
    txn(1, 1'b0, 8'h20, 16'h0, 0);

    // W=0: init and request collide; init wins, request accepted one cycle later.
    init_we[2] = 1'b1; init_addr[2] = 8'h33; init_data[2] = 16'h5A5A;
    req_valid[2] = 1'b1; req_write[2] = 1'b0; req_addr[2] = 8'h33;
    #1 chk("collide_req_ready", 2, 32'(req_ready[2]), 32'd0);
    @(posedge clock);
    @(negedge clock);
    init_we[2] = 1'b0;
    mdl[2][8'h33] = 16'h5A5A;
    #1 chk("collide_not_accepted", 2, 32'(req_ready[2]), 32'd1);
    chk("collide_no_rsp", 2, 32'(rsp_valid[2]), 32'd0);
    txn(2, 1'b0, 8'h33, 16'h0, 1);

    // Randomized traffic with occasional preloads between transactions.
    for (int i = 0; i < 120; i++) begin
      int d;
      logic [7:0] a;
      d = $urandom_range(0, N - 1);
      a = ($urandom_range(0, 3) == 0) ? 8'(8'hC0 + $urandom_range(0, 15)) : 8'($urandom);
      if ($urandom_range(0, 4) == 0) begin
        v = 16'($urandom);
        init_we[d] = 1'b1; init_addr[d] = a; init_data[d] = v;
        #1 chk("rand_init_ready", d, 32'(req_ready[d]), 32'd0);
        @(posedge clock);
        @(negedge clock);
        init_we[d] = 1'b0;
        if (int'(a) < depth_of(d)) mdl[d][a] = v;
      end
      txn(d, 1'($urandom), a, 16'($urandom), $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
